uart_hex_display: RTL and testbench
===================================

# uart_hex_display

Consumes bytes delivered by the UART receiver (`o_data` / `o_ready_to_read`) and shows the last two received bytes as four hex digits on the board's 4-digit, 7-segment display. It time-multiplexes the displays and drives segment, display and dot enables directly. It replaces the constant-enable tie-offs at the top level. The dot on the rightmost digit flashes as a byte-activity indicator.

## Interface
- `REFRESH_CYCLES`, default 50000: clock cycles each digit stays selected. Legal range is ≥ 2.
- `DOT_HOLD_CYCLES`, default 5000000: cycles the activity dot stays lit after a byte. Legal range is ≥ 1.
- `clk` (in, 1): single clock, driven from the generated clock.
- `i_reset` (in, 1): synchronous, active-high reset.
- `i_data` (in, [0:7]): received byte. Bit 0 is the MSB.
- `i_ready_to_read` (in, 1): byte-valid from the receiver. Any level or pulse width is accepted.
- `o_segment_enable` (out, [0:6]): segments a..g, index 0 = a. Active low (0 = lit).
- `o_display_enable` (out, [0:3]): digit select, index 0 = leftmost. Active low.
- `o_dot_enable` (out, 1): decimal point. Active low.

## Operation
- **Byte acceptance.**
  - A 1-cycle-delayed copy of `i_ready_to_read` is registered; its reset value is 0.
  - A byte is accepted on each edge where `i_ready_to_read` = 1 and the delayed copy = 0, i.e. on the rising edge only.
  - Holding the input high accepts exactly one byte.
- **Value register.**
  - 16-bit register, reset to 0x0000.
  - On accept it loads {value[7:0], i_data}, so the newest byte occupies digits 2–3.
- **Digit index.**
  - 2-bit register, reset to 0.
  - A refresh counter counts 0..REFRESH_CYCLES-1 (reset 0) and wraps to 0.
  - On the wrap edge the index advances 0→1→2→3→0.
- **Nibble select.**
  - Index 0 → value[15:12], 1 → [11:8], 2 → [7:4], 3 → [3:0].
- **Hex decode, a..g, active low:**
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- **Display enable.** One-hot low: bit[index] = 0, all other bits = 1.
- **Activity timer.**
  - Counter reset to 0. Loaded with DOT_HOLD_CYCLES on accept, otherwise decrements while nonzero.
  - An accept while the timer is nonzero reloads it; it is never additive.
- **Dot.** `o_dot_enable` = 0 iff index = 3 and timer ≠ 0; otherwise 1.
- **Registered outputs.** All three outputs are registered and computed from the current index, value and timer. Segment and display enables therefore always change on the same edge, with no glitch between digits.

## Timing
- **Reset values of outputs:**
  - `o_segment_enable` = 0000001 (digit "0")
  - `o_display_enable` = 0111
  - `o_dot_enable` = 1
  - Reset asserted mid-scan or mid-hold gives these values at the next edge and clears value, index, counters and the edge-detect register.
- **Output latency.** Outputs lag internal state by 1 cycle.
  - An accept at edge E updates value at E.
  - The selected digit shows the new nibble at E+1.
- **Scan rate.** Each digit is selected for exactly REFRESH_CYCLES consecutive cycles; a full frame is 4·REFRESH_CYCLES.
- **Accept on the index-advance edge.** Both updates take effect at that edge. The next output reflects the new index and the new value.
- **Back-to-back bytes.** Two rising edges of `i_ready_to_read` separated by one low cycle are both accepted. The minimum spacing is 2 cycles.
- **Dot duration.** The timer is nonzero for exactly DOT_HOLD_CYCLES cycles after the accept edge. The dot is visible only during digit-3 slots within that window, delayed 1 cycle.
- **Inputs during reset.** A byte presented while `i_reset` = 1 is ignored.

## Test plan
All scenarios use REFRESH_CYCLES = 4 and DOT_HOLD_CYCLES = 10.
- **Reset.** Hold `i_reset` 3 cycles, then release → outputs 0000001 / 0111 / 1; display_enable steps 0111→1011→1101→1110→0111, each held 4 cycles.
- **Single byte.** Send 0xA5 (1-cycle pulse) → value 0x00A5; digit 2 shows 0001000 (A) and digit 3 shows 0100100 (5); digits 0–1 show 0000001.
- **Two bytes.** Send 0x3C, then 0xE7 two cycles later → value 0x3CE7; digit 0 = 0000110, digit 1 = 0110001, digit 2 = 0110000, digit 3 = 0001111.
- **Held-high valid.** Hold `i_ready_to_read` high for 20 cycles with `i_data` = 0x12 → exactly one accept; value 0x0012.
- **Dot.** Send a byte, then observe → `o_dot_enable` = 0 only in digit-3 slots within 10 cycles after the accept (+1 cycle latency). A second byte sent at cycle 8 extends the window to cycle 18.
- **Reset mid-operation.** Send 0xFF, then assert `i_reset` on a digit-2 slot → next edge gives 0000001 / 0111 / 1 and value 0x0000.

Source files
------------

// File: rtl/uart_hex_display.sv
// Shows the last two bytes from the UART receiver as four hex digits on a
// time-multiplexed 4-digit 7-segment display, with a byte-activity dot on digit 3.
module uart_hex_display #(
    parameter int REFRESH_CYCLES  = 50000,
    parameter int DOT_HOLD_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic [0:7] i_data,
    input  logic       i_ready_to_read,
    output logic [0:6] o_segment_enable,
    output logic [0:3] o_display_enable,
    output logic       o_dot_enable
);

    localparam int REFRESH_W = $clog2(REFRESH_CYCLES);
    localparam int TIMER_W   = $clog2(DOT_HOLD_CYCLES + 1);

    localparam logic [REFRESH_W-1:0] REFRESH_LAST  = REFRESH_W'(REFRESH_CYCLES - 1);
    localparam logic [TIMER_W-1:0]   DOT_HOLD_LOAD = TIMER_W'(DOT_HOLD_CYCLES);

    localparam logic [1:0] DIGIT_0 = 2'd0;
    localparam logic [1:0] DIGIT_1 = 2'd1;
    localparam logic [1:0] DIGIT_2 = 2'd2;
    localparam logic [1:0] DIGIT_3 = 2'd3;

    localparam logic [0:6] SEG_ZERO  = 7'b0000001;
    localparam logic [0:3] DISP_IDLE = 4'b0111;

    logic                 ready_q;
    logic [15:0]          value_q,   value_d;
    logic [REFRESH_W-1:0] refresh_q, refresh_d;
    logic [1:0]           index_q,   index_d;
    logic [TIMER_W-1:0]   timer_q,   timer_d;
    logic [0:6]           seg_q,     seg_d;
    logic [0:3]           disp_q,    disp_d;
    logic                 dot_q,     dot_d;

    logic                 accept;
    logic                 refresh_wrap;
    logic [3:0]           nibble;

    function automatic logic [0:6] hex_to_seg(input logic [3:0] hex);
        logic [0:6] seg;
        case (hex)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // Rising-edge detect: a level held high loads exactly one byte.
    assign accept       = i_ready_to_read & ~ready_q;
    assign refresh_wrap = (refresh_q == REFRESH_LAST);

    always_comb begin
        // NOTE: every signal gets a default up front so no path can leave it
        // unassigned, which would otherwise infer a latch.
        value_d   = value_q;
        refresh_d = refresh_q + 1'b1;
        index_d   = index_q;
        timer_d   = timer_q;
        nibble    = value_q[3:0];

        if (accept) begin
            value_d = {value_q[7:0], i_data};
        end

        if (refresh_wrap) begin
            refresh_d = '0;
            index_d   = index_q + 2'd1;
        end

        // Reload rather than extend: the dot tracks only the most recent byte.
        if (accept) begin
            timer_d = DOT_HOLD_LOAD;
        end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end

        case (index_q)
            DIGIT_0: nibble = value_q[15:12];
            DIGIT_1: nibble = value_q[11:8];
            DIGIT_2: nibble = value_q[7:4];
            default: nibble = value_q[3:0];
        endcase

        seg_d          = hex_to_seg(nibble);
        disp_d         = 4'b1111;
        disp_d[index_q] = 1'b0;
        dot_d          = !((index_q == DIGIT_3) && (timer_q != '0));
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every register
        // samples the pre-edge values, independent of statement order.
        if (i_reset) begin
            ready_q   <= 1'b0;
            value_q   <= 16'h0000;
            refresh_q <= '0;
            index_q   <= DIGIT_0;
            timer_q   <= '0;
            seg_q     <= SEG_ZERO;
            disp_q    <= DISP_IDLE;
            dot_q     <= 1'b1;
        end else begin
            ready_q   <= i_ready_to_read;
            value_q   <= value_d;
            refresh_q <= refresh_d;
            index_q   <= index_d;
            timer_q   <= timer_d;
            seg_q     <= seg_d;
            disp_q    <= disp_d;
            dot_q     <= dot_d;
        end
    end

    assign o_segment_enable = seg_q;
    assign o_display_enable = disp_q;
    assign o_dot_enable     = dot_q;

endmodule

// File: tb/tb_uart_hex_display.sv
// Bench for uart_hex_display: per-cycle scan/dot checks against a cycle-count
// formula, plus a frame scoreboard for the displayed digits.
module tb_uart_hex_display;

    localparam int REFRESH = 4;
    localparam int HOLD    = 10;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [0:7] i_data = 8'h00;
    logic       i_ready_to_read = 1'b0;
    logic [0:6] o_segment_enable;
    logic [0:3] o_display_enable;
    logic       o_dot_enable;

    always #5 clk = ~clk;

    uart_hex_display #(
        .REFRESH_CYCLES (REFRESH),
        .DOT_HOLD_CYCLES(HOLD)
    ) dut (
        .clk             (clk),
        .i_reset         (i_reset),
        .i_data          (i_data),
        .i_ready_to_read (i_ready_to_read),
        .o_segment_enable(o_segment_enable),
        .o_display_enable(o_display_enable),
        .o_dot_enable    (o_dot_enable)
    );

    typedef struct {
        logic [7:0]  data;
        logic [15:0] exp_value;
    } vec_t;

    vec_t vecs[8];

    logic [6:0] hex7 [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic [27:0] sb[$];
    int          acc_q[$];
    int          t = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    // Edge number since the last reset edge (the reset edge itself is 0).
    always @(posedge clk) begin
        if (i_reset) t <= 0;
        else         t <= t + 1;
    end

    // Outputs after edge t reflect the index/timer after edge t-1.
    always @(negedge clk) begin
        int         e;
        int         k;
        bit         nz;
        logic [3:0] exp_disp;
        logic       exp_dot;
        if (mon_en) begin
            if (t == 0) begin
                exp_disp = 4'b0111;
                exp_dot  = 1'b1;
            end else begin
                e  = t - 1;
                k  = (e / REFRESH) % 4;
                nz = 1'b0;
                foreach (acc_q[i]) if (e >= acc_q[i] && e - acc_q[i] < HOLD) nz = 1'b1;
                exp_disp = ~(4'b1000 >> k);
                exp_dot  = !(k == 3 && nz);
            end
            check("scan_disp", o_display_enable, exp_disp);
            check("scan_dot", o_dot_enable, exp_dot);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_dut(input int n);
        i_reset = 1'b1;
        i_ready_to_read = 1'b0;
        acc_q.delete();
        repeat (n) step();
        i_reset = 1'b0;
        check("rst_seg", o_segment_enable, 7'b0000001);
        check("rst_disp", o_display_enable, 4'b0111);
        check("rst_dot", o_dot_enable, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] d);
        step();
        i_data = d;
        i_ready_to_read = 1'b1;
        if (!i_reset) acc_q.push_back(t + 1);
        step();
        i_ready_to_read = 1'b0;
    endtask

    task automatic expect_value(input logic [15:0] v);
        sb.push_back({hex7[v[15:12]], hex7[v[11:8]], hex7[v[7:4]], hex7[v[3:0]]});
    endtask

    task automatic check_frame(input string name);
        logic [27:0] f;
        logic [3:0]  pat;
        int          n;
        repeat (2) step();
        check({name, "_sb_nonempty"}, sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
            while (sb.size() > 1) f = sb.pop_front();
            f = sb.pop_front();
            for (int d = 0; d < 4; d++) begin
                pat = ~(4'b1000 >> d);
                n = 0;
                while (o_display_enable !== pat && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                check($sformatf("%s_reach_d%0d", name, d), n < 40, 1'b1);
                if (n < 40) check($sformatf("%s_seg_d%0d", name, d), o_segment_enable, f[27 - 7*d -: 7]);
            end
        end
    endtask

    task automatic wait_t(input int target);
        int n = 0;
        while (t != target && n < 200) begin
            step();
            n++;
        end
        check("wait_t", t, target);
    endtask

    task automatic count_dots(input int cycles, output int lows);
        lows = 0;
        repeat (cycles) begin
            step();
            if (o_dot_enable === 1'b0) lows++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        int lows;

        vecs[0] = '{8'hA5, 16'h00A5};
        vecs[1] = '{8'h3C, 16'hA53C};
        vecs[2] = '{8'hE7, 16'h3CE7};
        vecs[3] = '{8'h01, 16'hE701};
        vecs[4] = '{8'h9B, 16'h019B};
        vecs[5] = '{8'hF8, 16'h9BF8};
        vecs[6] = '{8'hD2, 16'hF8D2};
        vecs[7] = '{8'h46, 16'hD246};

        reset_dut(3);
        mon_en = 1'b1;

        // Slot length after reset
        n = 0;
        while (o_display_enable !== 4'b1011 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("scan_start", n < 40, 1'b1);
        len = 0;
        while (o_display_enable === 4'b1011 && len < 40) begin
            len++;
            @(negedge clk);
        end
        check("scan_len", len, REFRESH);

        expect_value(16'h0000);
        check_frame("reset");

        foreach (vecs[i]) begin
            send_byte(vecs[i].data);
            expect_value(vecs[i].exp_value);
            check_frame($sformatf("vec%0d", i));
        end

        // Back-to-back bytes with one low cycle between them
        reset_dut(2);
        send_byte(8'h3C);
        send_byte(8'hE7);
        expect_value(16'h3CE7);
        check_frame("b2b");

        // Held-high valid loads exactly one byte
        reset_dut(2);
        step();
        i_data = 8'h12;
        i_ready_to_read = 1'b1;
        acc_q.push_back(t + 1);
        repeat (20) step();
        i_ready_to_read = 1'b0;
        expect_value(16'h0012);
        check_frame("held");

        // Byte offered during reset is ignored
        i_reset = 1'b1;
        acc_q.delete();
        step();
        i_data = 8'h77;
        i_ready_to_read = 1'b1;
        step();
        i_ready_to_read = 1'b0;
        step();
        i_reset = 1'b0;
        expect_value(16'h0000);
        check_frame("rst_ignore");

        // Dot window from a single accept at edge 4
        reset_dut(2);
        wait_t(2);
        send_byte(8'h5A);
        count_dots(30, lows);
        check("dot_single_lows", lows, 2);

        // Second accept at edge 12 reloads the window into the digit-3 slot
        reset_dut(2);
        wait_t(2);
        send_byte(8'h5A);
        wait_t(10);
        send_byte(8'hC3);
        count_dots(30, lows);
        check("dot_reload_lows", lows, 4);

        // Reset asserted during a digit-2 slot
        reset_dut(2);
        send_byte(8'hFF);
        expect_value(16'h00FF);
        check_frame("pre_rst");
        n = 0;
        while (o_display_enable !== 4'b1101 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_reach", n < 40, 1'b1);
        #1;
        i_reset = 1'b1;
        acc_q.delete();
        step();
        check("mid_rst_seg", o_segment_enable, 7'b0000001);
        check("mid_rst_disp", o_display_enable, 4'b0111);
        check("mid_rst_dot", o_dot_enable, 1'b1);
        step();
        i_reset = 1'b0;
        expect_value(16'h0000);
        check_frame("post_rst");

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
